// File: rtl/vga_console_writer_if.sv
// Character stream into the console writer, plus its VRAM write port and status.
// master = character producer / observer, slave = the writer block.
interface vga_console_writer_if;
    logic [7:0]  in_data;
    logic [7:0]  in_attr;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] vram_waddr;
    logic [15:0] vram_wdata;
    logic        vram_we;
    logic [4:0]  cursor_row;
    logic [5:0]  cursor_col;
    logic        busy;

    modport master (
        output in_data, in_attr, in_valid,
        input  in_ready, vram_waddr, vram_wdata, vram_we, cursor_row, cursor_col, busy
    );

    modport slave (
        input  in_data, in_attr, in_valid,
        output in_ready, vram_waddr, vram_wdata, vram_we, cursor_row, cursor_col, busy
    );
endinterface

// File: rtl/vga_console_writer.sv
// Text console writer: turns a character stream into VRAM cell writes, handling
// CR/LF/BS/FF, line wrap and row/screen clears one cell per cycle.
module vga_console_writer #(
    parameter int          COLS = 40,
    parameter int          ROWS = 30,
    parameter logic [15:0] FILL = 16'h0020
) (
    input  logic clk,
    input  logic rst_n,
    vga_console_writer_if.slave bus
);
    localparam int CELLS = COLS * ROWS;

    typedef enum logic [1:0] {IDLE, CLRSCR, CLRROW} state_t;

    state_t      state;
    logic [4:0]  row;
    logic [5:0]  col;
    logic [10:0] row_base;
    logic [10:0] clr_addr;
    logic [5:0]  clr_col;
    logic        we_q;
    logic [10:0] waddr_q;
    logic [15:0] wdata_q;
    logic        busy_q;
    logic        ready_q;

    logic        accept;
    logic        printable;
    logic        enter_row;
    logic [4:0]  next_row;
    logic [10:0] next_base;
    logic [10:0] cur_addr;

    // row_base tracks row*COLS so no multiplier is needed for the cell address
    always_comb begin
        accept    = bus.in_valid && ready_q;
        printable = (bus.in_data >= 8'h20) && (bus.in_data <= 8'h7E);
        next_row  = (row == 5'(ROWS - 1)) ? 5'd0 : row + 5'd1;
        next_base = (row == 5'(ROWS - 1)) ? 11'd0 : row_base + 11'(COLS);
        cur_addr  = row_base + {5'd0, col};
        enter_row = accept && (state == IDLE) &&
                    ((printable && (col == 6'(COLS - 1))) || (bus.in_data == 8'h0A));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= CLRSCR;
            row      <= '0;
            col      <= '0;
            row_base <= '0;
            clr_addr <= '0;
            clr_col  <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            busy_q   <= 1'b1;
            ready_q  <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state)
                CLRSCR: begin
                    we_q    <= 1'b1;
                    waddr_q <= clr_addr;
                    wdata_q <= FILL;
                    if (clr_addr == 11'(CELLS - 1)) begin
                        state   <= IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        clr_addr <= clr_addr + 11'd1;
                    end
                end
                CLRROW: begin
                    we_q     <= 1'b1;
                    waddr_q  <= clr_addr;
                    wdata_q  <= FILL;
                    clr_addr <= clr_addr + 11'd1;
                    clr_col  <= clr_col + 6'd1;
                    if (clr_col == 6'(COLS - 1)) begin
                        state   <= IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                IDLE: begin
                    if (accept) begin
                        if (printable) begin
                            we_q    <= 1'b1;
                            waddr_q <= cur_addr;
                            wdata_q <= {bus.in_attr, bus.in_data};
                            col     <= (col == 6'(COLS - 1)) ? 6'd0 : col + 6'd1;
                        end else if (bus.in_data == 8'h0A || bus.in_data == 8'h0D) begin
                            col <= '0;
                        end else if (bus.in_data == 8'h08) begin
                            if (col != 6'd0) begin
                                col     <= col - 6'd1;
                                we_q    <= 1'b1;
                                waddr_q <= cur_addr - 11'd1;
                                wdata_q <= FILL;
                            end
                        end else if (bus.in_data == 8'h0C) begin
                            state    <= CLRSCR;
                            clr_addr <= '0;
                            row      <= '0;
                            col      <= '0;
                            row_base <= '0;
                            busy_q   <= 1'b1;
                            ready_q  <= 1'b0;
                        end
                        // Wrap and LF both land here; the new row is cleared before more input
                        if (enter_row) begin
                            row      <= next_row;
                            row_base <= next_base;
                            clr_addr <= next_base;
                            clr_col  <= '0;
                            state    <= CLRROW;
                            busy_q   <= 1'b1;
                            ready_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= CLRSCR;
                    clr_addr <= '0;
                    busy_q   <= 1'b1;
                    ready_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = ready_q;
    assign bus.busy       = busy_q;
    assign bus.vram_we    = we_q;
    assign bus.vram_waddr = waddr_q;
    assign bus.vram_wdata = wdata_q;
    assign bus.cursor_row = row;
    assign bus.cursor_col = col;
endmodule

// File: tb/tb_vga_console_writer.sv
// Randomized bench for vga_console_writer against a cursor/write-list reference model.
module tb_vga_console_writer;
    localparam int          COLS  = 40;
    localparam int          ROWS  = 30;
    localparam logic [15:0] FILL  = 16'h0020;
    localparam int          CELLS = COLS * ROWS;

    logic clk;
    logic rst_n;
    vga_console_writer_if bus ();

    vga_console_writer #(.COLS(COLS), .ROWS(ROWS), .FILL(FILL)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // reference model: cursor plus ordered list of writes still to be observed
    int mr = 0;
    int mc = 0;
    logic [26:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void push_write(input int addr, input logic [15:0] data);
        exp_q.push_back({addr[10:0], data});
    endfunction

    function automatic void model_clear_all();
        for (int a = 0; a < CELLS; a++) push_write(a, FILL);
        mr = 0;
        mc = 0;
    endfunction

    function automatic void model_new_row();
        mr = (mr + 1) % ROWS;
        mc = 0;
        for (int k = 0; k < COLS; k++) push_write(mr * COLS + k, FILL);
    endfunction

    // returns 1 = immediate write, 0 = no write, 2 = not checked for latency
    function automatic int model_apply(input logic [7:0] d, input logic [7:0] a);
        int imm;
        imm = 0;
        if (d >= 8'h20 && d <= 8'h7E) begin
            push_write(mr * COLS + mc, {a, d});
            imm = 1;
            mc++;
            if (mc == COLS) model_new_row();
        end else if (d == 8'h0A) begin
            model_new_row();
            imm = 2;
        end else if (d == 8'h0D) begin
            mc = 0;
        end else if (d == 8'h08) begin
            if (mc > 0) begin
                mc--;
                push_write(mr * COLS + mc, FILL);
                imm = 1;
            end
        end else if (d == 8'h0C) begin
            model_clear_all();
            imm = 2;
        end
        return imm;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            check("ready_vs_busy", {31'd0, bus.in_ready}, {31'd0, !bus.busy});
            if (bus.vram_we) begin
                if (exp_q.size() == 0) begin
                    check("spurious_write", {21'd0, bus.vram_waddr}, 32'hFFFF_FFFF);
                end else begin
                    logic [26:0] e;
                    e = exp_q.pop_front();
                    check("waddr", {21'd0, bus.vram_waddr}, {21'd0, e[26:16]});
                    check("wdata", {16'd0, bus.vram_wdata}, {16'd0, e[15:0]});
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic [7:0] a);
        int n;
        int imm;
        @(negedge clk);
        bus.in_data  = d;
        bus.in_attr  = a;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        imm = model_apply(d, a);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        check("cursor_row", {27'd0, bus.cursor_row}, mr);
        check("cursor_col", {26'd0, bus.cursor_col}, mc);
        if (imm != 2) check("we_latency", {31'd0, bus.vram_we}, imm);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!bus.in_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) check("idle_timeout", 32'd0, 32'd1);
        @(negedge clk);
        check("writes_drained", exp_q.size(), 32'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_we", {31'd0, bus.vram_we}, 32'd0);
        check("rst_waddr", {21'd0, bus.vram_waddr}, 32'd0);
        check("rst_wdata", {16'd0, bus.vram_wdata}, 32'd0);
        check("rst_row", {27'd0, bus.cursor_row}, 32'd0);
        check("rst_col", {26'd0, bus.cursor_col}, 32'd0);
        check("rst_ready", {31'd0, bus.in_ready}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd1);
    endtask

    task automatic release_reset();
        @(negedge clk);
        exp_q.delete();
        model_clear_all();
        rst_n = 1'b1;
        wait_idle();
        check("post_clear_row", {27'd0, bus.cursor_row}, 32'd0);
        check("post_clear_col", {26'd0, bus.cursor_col}, 32'd0);
    endtask

    function automatic logic [7:0] rand_print();
        return 8'($urandom_range(32, 126));
    endfunction

    initial begin
        logic [7:0] c;
        int sel;
        rst_n        = 1'b0;
        bus.in_data  = '0;
        bus.in_attr  = '0;
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        release_reset();

        // single 'A' with attribute 0x07
        send(8'h41, 8'h07);
        check("A_waddr", {21'd0, bus.vram_waddr}, 32'd0);
        check("A_wdata", {16'd0, bus.vram_wdata}, 32'h0741);
        wait_idle();

        // full row of text from (5,0) wraps into row 6 with a row clear
        repeat (5) begin send(8'h0A, 8'h00); wait_idle(); end
        check("row5", {27'd0, bus.cursor_row}, 32'd5);
        for (int i = 0; i < COLS; i++) send(rand_print(), 8'($urandom));
        wait_idle();
        check("wrap_row", {27'd0, bus.cursor_row}, 32'd6);
        check("wrap_col", {26'd0, bus.cursor_col}, 32'd0);

        // LF on the last row wraps to row 0 and clears it
        repeat (23) begin send(8'h0A, 8'h00); wait_idle(); end
        repeat (3) send(rand_print(), 8'h1F);
        check("bottom_row", {27'd0, bus.cursor_row}, 32'd29);
        check("bottom_col", {26'd0, bus.cursor_col}, 32'd3);
        send(8'h0A, 8'h00);
        wait_idle();
        check("lf_wrap_row", {27'd0, bus.cursor_row}, 32'd0);

        // backspace at column 0 is a no-op, elsewhere it blanks the previous cell
        repeat (2) begin send(8'h0A, 8'h00); wait_idle(); end
        send(8'h08, 8'h00);
        check("bs0_row", {27'd0, bus.cursor_row}, 32'd2);
        check("bs0_col", {26'd0, bus.cursor_col}, 32'd0);
        repeat (7) send(rand_print(), 8'h42);
        send(8'h08, 8'h00);
        check("bs_waddr", {21'd0, bus.vram_waddr}, 32'd86);
        check("bs_wdata", {16'd0, bus.vram_wdata}, {16'd0, FILL});
        check("bs_col", {26'd0, bus.cursor_col}, 32'd6);

        // random character mix
        for (int i = 0; i < 250; i++) begin
            sel = $urandom_range(0, 99);
            if (sel < 70)      c = rand_print();
            else if (sel < 78) c = 8'h0A;
            else if (sel < 84) c = 8'h0D;
            else if (sel < 92) c = 8'h08;
            else if (sel < 97) c = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7))
                                                               : 8'($urandom_range(127, 255));
            else               c = 8'h0C;
            send(c, 8'($urandom));
        end
        wait_idle();

        // reset pulse in the middle of a form-feed clear
        send(8'h0C, 8'h00);
        repeat (100) @(negedge clk);
        #2 rst_n = 1'b0;
        exp_q.delete();
        mr = 0;
        mc = 0;
        #1 check_reset_outputs();
        repeat (2) @(negedge clk);
        release_reset();

        send(8'h5A, 8'h70);
        check("after_rst_waddr", {21'd0, bus.vram_waddr}, 32'd0);
        check("after_rst_wdata", {16'd0, bus.vram_wdata}, 32'h705A);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
